// File: rtl/fsm_pkg.sv
// Shared definitions for the coin/key front end of the cola vending machine.
//   - State encoding of the debounce FSM (also used by debug tooling).
//   - Default debounce window: 20 ms at 50 MHz.
package fsm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FILT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_FILT_UP = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FILT_DN = ST_FILT_DN,
    DOWN    = ST_DOWN,
    FILT_UP = ST_FILT_UP
  } state_t;

  localparam int CNT_MAX_50M = 999_999;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous, active-high reset; both flops load RST_VAL
//   d    - asynchronous input
//   q    - synchronized output (two clk edges of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/coin_key_filter.sv
// Coin sensor conditioner: turns a raw, bouncing, active-low coin/key input
// into a clean one-cycle coin pulse for the vending FSM, plus a debounced
// pressed level and a running count of accepted coins.
// Ports:
//   sys_clk  - system clock, all logic on the rising edge
//   sys_rst  - asynchronous, active-high reset
//   key_in   - raw sensor, active-low, asynchronous, may bounce
//   po_money - one-cycle pulse per accepted coin (drives the FSM's pi_money)
//   key_flag - debounced pressed level (1 = pressed)
//   coin_cnt - accepted coins, wraps modulo 2^COIN_W
//
// A level change is accepted only after the synchronized input has held the
// new level on CNT_MAX+1 consecutive edges (entry edge plus CNT_MAX counts).
module coin_key_filter
  import fsm_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_50M,
  parameter int CNT_W   = $clog2(CNT_MAX),
  parameter int COIN_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key_in,
  output logic              po_money,
  output logic              key_flag,
  output logic [COIN_W-1:0] coin_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic key_s;  // synchronized key, 0 = pressed

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (key_in),
    .q   (key_s)
  );

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                po_money_q, po_money_d;
  logic                key_flag_q, key_flag_d;
  logic [COIN_W-1:0]   coin_cnt_q, coin_cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    po_money_d = 1'b0;  // pulse lasts exactly one cycle
    key_flag_d = key_flag_q;
    coin_cnt_d = coin_cnt_q;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = FILT_DN;
          cnt_d   = '0;
        end
      end
      FILT_DN: begin
        if (key_s) begin
          state_d = IDLE;  // press bounce rejected
        end else if (cnt_q == CNT_LAST) begin
          state_d    = DOWN;
          po_money_d = 1'b1;
          key_flag_d = 1'b1;
          coin_cnt_d = coin_cnt_q + COIN_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = FILT_UP;
          cnt_d   = '0;
        end
      end
      FILT_UP: begin
        if (!key_s) begin
          state_d = DOWN;  // release bounce, still pressed, no new coin
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          key_flag_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      po_money_q <= 1'b0;
      key_flag_q <= 1'b0;
      coin_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      po_money_q <= po_money_d;
      key_flag_q <= key_flag_d;
      coin_cnt_q <= coin_cnt_d;
    end
  end

  assign po_money = po_money_q;
  assign key_flag = key_flag_q;
  assign coin_cnt = coin_cnt_q;

endmodule

// File: tb/tb_coin_key_filter.sv
// Bench for coin_key_filter with CNT_MAX = 10, COIN_W = 8, 10 ns clock.
// Reference model: the filter sees key_in as sampled two edges earlier; a
// level change is accepted once that delayed sample has shown the opposite
// level on CNT_MAX+1 consecutive edges. Each acceptance of a press yields one
// coin pulse and one count.
module tb_coin_key_filter;

  localparam int CNT_MAX = 10;
  localparam int COIN_W  = 8;
  localparam int LAT     = CNT_MAX + 2;
  localparam int MIN_GAP = 2 * CNT_MAX + 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              key_in;
  logic              po_money;
  logic              key_flag;
  logic [COIN_W-1:0] coin_cnt;

  coin_key_filter #(
    .CNT_MAX (CNT_MAX),
    .COIN_W  (COIN_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .po_money (po_money),
    .key_flag (key_flag),
    .coin_cnt (coin_cnt)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic              kq[$];
  logic              m_pressed = 1'b0;
  int                m_run     = 0;
  logic [COIN_W-1:0] m_cnt     = '0;
  logic              m_pulse   = 1'b0;

  int   pulses         = 0;
  int   last_pulse_cyc = -1000;
  int   flag_fall_cyc  = -1;
  logic prev_po        = 1'b0;
  logic prev_flag      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic s;
    logic moving;
    if (sys_rst) begin
      kq.delete();
      m_pressed = 1'b0;
      m_run     = 0;
      m_cnt     = '0;
      m_pulse   = 1'b0;
      return;
    end
    kq.push_back(key_in);
    if (kq.size() > 4) void'(kq.pop_front());
    s = (kq.size() >= 3) ? kq[kq.size()-3] : 1'b1;
    m_pulse = 1'b0;
    moving  = m_pressed ? (s == 1'b1) : (s == 1'b0);
    m_run   = moving ? m_run + 1 : 0;
    if (m_run == CNT_MAX + 1) begin
      m_run     = 0;
      m_pressed = ~m_pressed;
      if (m_pressed) begin
        m_pulse = 1'b1;
        m_cnt   = m_cnt + 1'b1;
      end
    end
  endtask

  task automatic compare();
    chk("po_money", 32'(po_money), 32'(m_pulse));
    chk("key_flag", 32'(key_flag), 32'(m_pressed));
    chk("coin_cnt", 32'(coin_cnt), 32'(m_cnt));
    if (po_money === 1'b1) begin
      chk("pulse_single", 32'(prev_po), 32'd0);
      chk("pulse_gap_ok", 32'((cyc - last_pulse_cyc) >= MIN_GAP), 32'd1);
      pulses++;
      last_pulse_cyc = cyc;
    end
    if (prev_flag === 1'b1 && key_flag === 1'b0) flag_fall_cyc = cyc;
    prev_po   = po_money;
    prev_flag = key_flag;
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      model_step();
      #2;
      compare();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int base;
    logic v;
    logic [COIN_W-1:0] cnt0;

    sys_rst = 1'b1;
    key_in  = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_po_money", 32'(po_money), 32'd0);
    chk("rst_key_flag", 32'(key_flag), 32'd0);
    chk("rst_coin_cnt", 32'(coin_cnt), 32'd0);
    sys_rst = 1'b0;
    hold(1'b1, 5);

    // clean press, held 40 cycles
    base = pulses;
    k = cyc + 1;
    hold(1'b0, 40);
    chk("press_latency", 32'(last_pulse_cyc - k), 32'(LAT));
    chk("press_pulses", 32'(pulses - base), 32'd1);
    chk("press_flag", 32'(key_flag), 32'd1);
    chk("press_cnt", 32'(coin_cnt), 32'd1);

    // clean release
    k = cyc + 1;
    hold(1'b1, 30);
    chk("release_latency", 32'(flag_fall_cyc - k), 32'(LAT));
    chk("release_no_pulse", 32'(pulses - base), 32'd1);

    // press bounce: low 6, high 3, then low held
    base = pulses;
    hold(1'b0, 6);
    hold(1'b1, 3);
    k = cyc + 1;
    hold(1'b0, 30);
    chk("pbounce_latency", 32'(last_pulse_cyc - k), 32'(LAT));
    chk("pbounce_pulses", 32'(pulses - base), 32'd1);
    chk("pbounce_cnt", 32'(coin_cnt), 32'd2);

    // release bounce: high 5, low 2, then high held
    flag_fall_cyc = -1;
    hold(1'b1, 5);
    hold(1'b0, 2);
    chk("rbounce_flag_held", 32'(key_flag), 32'd1);
    k = cyc + 1;
    hold(1'b1, 30);
    chk("rbounce_latency", 32'(flag_fall_cyc - k), 32'(LAT));
    chk("rbounce_no_pulse", 32'(pulses - base), 32'd1);

    // counter wrap over 256 coins
    do_reset(2);
    hold(1'b1, 5);
    base = pulses;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 30);
      if (i == 254) chk("wrap_255", 32'(coin_cnt), 32'd255);
      if (i == 255) chk("wrap_0", 32'(coin_cnt), 32'd0);
      hold(1'b1, 30);
    end
    chk("wrap_pulses", 32'(pulses - base), 32'd256);

    // reset in the middle of the press filter (cnt = 5)
    base = pulses;
    k = cyc + 1;
    hold(1'b0, 8);
    sys_rst = 1'b1;
    chk("midrst_no_early_pulse", 32'(pulses - base), 32'd0);
    @(posedge sys_clk);
    #2;
    chk("midrst_po_money", 32'(po_money), 32'd0);
    chk("midrst_key_flag", 32'(key_flag), 32'd0);
    chk("midrst_coin_cnt", 32'(coin_cnt), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    k = cyc + 1;
    hold(1'b0, 30);
    chk("midrst_pulses", 32'(pulses - base), 32'd1);
    chk("midrst_latency", 32'(last_pulse_cyc - k), 32'(LAT));
    chk("midrst_cnt", 32'(coin_cnt), 32'd1);
    hold(1'b1, 30);

    // random press/release sequence with bounces
    cnt0 = coin_cnt;
    base = pulses;
    v = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int nb;
      v = ~v;
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) hold((b % 2 == 0) ? v : ~v, $urandom_range(1, 5));
      end
      hold(v, $urandom_range(13, 40));
    end
    hold(1'b1, 40);
    chk("rand_cnt_matches_pulses", 32'(coin_cnt), 32'(cnt0 + COIN_W'(pulses - base)));
    chk("rand_flag_released", 32'(key_flag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
